hamming_decoder_7to4: RTL and testbench

Streaming Hamming(7,4) decoder for the receive path, after FSK demodulation and byte framing. It accepts 8-bit code words in the encoder's format, `{marker=1, p3, p2, p1, d3, d2, d1, d0}`, and computes the 3-bit syndrome. It corrects any single-bit error in bits 6..0 and delivers the 4-bit data word with status flags through a two-stage valid/ready pipeline. Optional saturating statistics counters feed link-quality reporting.

---
 rtl/hamming_pkg.sv | 42 ++++
 rtl/hamming_syndrome_7to4.sv | 21 ++
 rtl/hamming_decoder_7to4.sv | 145 ++++++++++++++
 tb/tb_hamming_decoder_7to4.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by both the encoder and the decoder so
// the bit layout {marker, p3, p2, p1, d3, d2, d1, d0} stays consistent.
package hamming_pkg;

    localparam int MARKER_BIT = 7;
    localparam int P3_BIT     = 6;
    localparam int P2_BIT     = 5;
    localparam int P1_BIT     = 4;
    localparam int D3_BIT     = 3;
    localparam int D2_BIT     = 2;
    localparam int D1_BIT     = 1;
    localparam int D0_BIT     = 0;

    localparam int CODE_W = 8;
    localparam int DATA_W = 4;

    typedef logic [2:0] syndrome_t;
    typedef logic [2:0] bitpos_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
        logic              marker_err;
    } dec_result_t;

    // A zero syndrome maps to the marker position, which is never flipped.
    function automatic bitpos_t syndrome_to_pos(input syndrome_t s);
        bitpos_t pos;
        case (s)
            3'b001:  pos = bitpos_t'(P1_BIT);
            3'b010:  pos = bitpos_t'(P2_BIT);
            3'b100:  pos = bitpos_t'(P3_BIT);
            3'b011:  pos = bitpos_t'(D0_BIT);
            3'b110:  pos = bitpos_t'(D1_BIT);
            3'b111:  pos = bitpos_t'(D2_BIT);
            3'b101:  pos = bitpos_t'(D3_BIT);
            default: pos = bitpos_t'(MARKER_BIT);
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome_7to4.sv
// Combinational syndrome and marker check for one received Hamming(7,4) code word.
module hamming_syndrome_7to4
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] word_i,
    output syndrome_t         syndrome_o,
    output logic              marker_err_o
);

    logic s1;
    logic s2;
    logic s3;

    assign s1 = word_i[P1_BIT] ^ word_i[D3_BIT] ^ word_i[D2_BIT] ^ word_i[D0_BIT];
    assign s2 = word_i[P2_BIT] ^ word_i[D2_BIT] ^ word_i[D1_BIT] ^ word_i[D0_BIT];
    assign s3 = word_i[P3_BIT] ^ word_i[D3_BIT] ^ word_i[D2_BIT] ^ word_i[D1_BIT];

    assign syndrome_o   = {s3, s2, s1};
    assign marker_err_o = ~word_i[MARKER_BIT];

endmodule

// File: rtl/hamming_decoder_7to4.sv
// Two-stage streaming Hamming(7,4) decoder with valid/ready handshakes.
// Define HAMMING_DEC_STATS_EN to build the saturating statistics counters.
module hamming_decoder_7to4
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_data,
    output logic              out_corrected,
    output logic              out_marker_err,
    input  logic              clear_stats,
    output logic [CNT_W-1:0]  stat_corrected,
    output logic [CNT_W-1:0]  stat_marker_err
);

    syndrome_t   in_syn;
    logic        in_merr;

    // Parity bits are fully captured by the syndrome, so only the data nibble is kept.
    logic        s1_valid_q, s1_valid_d;
    logic [3:0]  s1_data_q,  s1_data_d;
    syndrome_t   s1_syn_q,   s1_syn_d;
    logic        s1_merr_q,  s1_merr_d;

    logic        s2_valid_q, s2_valid_d;
    dec_result_t s2_res_q,   s2_res_d;

    logic        s1_advance;
    logic        s2_advance;
    bitpos_t     flip_pos;
    logic [3:0]  data_flip;

    hamming_syndrome_7to4 u_syndrome (
        .word_i       (in_data),
        .syndrome_o   (in_syn),
        .marker_err_o (in_merr)
    );

    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;

    assign flip_pos  = syndrome_to_pos(s1_syn_q);
    assign data_flip = flip_pos[2] ? 4'b0000 : (4'b0001 << flip_pos[1:0]);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s1_merr_d  = s1_merr_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (s1_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data[3:0];
                s1_syn_d  = in_syn;
                s1_merr_d = in_merr;
            end
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d.data       = s1_data_q ^ data_flip;
                s2_res_d.corrected  = (s1_syn_q != 3'b000);
                s2_res_d.marker_err = s1_merr_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_merr_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            s1_merr_q  <= s1_merr_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = s2_res_q.data;
    assign out_corrected  = s2_res_q.corrected;
    assign out_marker_err = s2_res_q.marker_err;

`ifdef HAMMING_DEC_STATS_EN
    logic              out_xfer;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_merr_q, cnt_merr_d;

    assign out_xfer = s2_valid_q && out_ready;

    // Clearing wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_merr_d = cnt_merr_q;
        if (clear_stats) begin
            cnt_corr_d = '0;
            cnt_merr_d = '0;
        end else if (out_xfer) begin
            if (s2_res_q.corrected && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (s2_res_q.marker_err && (cnt_merr_q != '1)) begin
                cnt_merr_d = cnt_merr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_corr_q <= '0;
            cnt_merr_q <= '0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_merr_q <= cnt_merr_d;
        end
    end

    assign stat_corrected  = cnt_corr_q;
    assign stat_marker_err = cnt_merr_q;
`else
    logic unused_clear_stats;

    assign unused_clear_stats = clear_stats;
    assign stat_corrected     = '0;
    assign stat_marker_err    = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_7to4.sv
// Directed self-checking bench for hamming_decoder_7to4 (CNT_W=2).
// Counter expectations follow HAMMING_DEC_STATS_EN; without it they must read 0.
module tb_hamming_decoder_7to4;

    localparam int CNT_W = 2;
`ifdef HAMMING_DEC_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [7:0]       inData = 8'h00;
    logic             outValid;
    logic             outReady = 1'b1;
    logic [3:0]       outData;
    logic             outCorrected;
    logic             outMarkerErr;
    logic             clearStats = 1'b0;
    logic [CNT_W-1:0] statCorrected;
    logic [CNT_W-1:0] statMarkerErr;

    int checks = 0;
    int errors = 0;

    hamming_decoder_7to4 #(.CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (inValid),
        .in_ready        (inReady),
        .in_data         (inData),
        .out_valid       (outValid),
        .out_ready       (outReady),
        .out_data        (outData),
        .out_corrected   (outCorrected),
        .out_marker_err  (outMarkerErr),
        .clear_stats     (clearStats),
        .stat_corrected  (statCorrected),
        .stat_marker_err (statMarkerErr)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        inValid  = v;
        inData   = d;
        outReady = r;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] statExp(input int n);
        return (STATS != 0) ? n : 0;
    endfunction

    // One isolated word: accepted at the first edge, visible after the second, drained at the third.
    task automatic sendSingle(input string tag, input logic [7:0] word, input logic [3:0] expData,
                              input logic expCorr, input logic expMerr, input logic [2:0] expSyn);
        applyStimulus(1'b1, word, 1'b1);
        nextCycle();
        checkOutput({tag, "_syndrome"}, dut.s1_syn_q, expSyn);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput({tag, "_not_yet_valid"}, outValid, 1'b0);
        nextCycle();
        checkOutput({tag, "_valid"}, outValid, 1'b1);
        checkOutput({tag, "_data"}, outData, expData);
        checkOutput({tag, "_corrected"}, outCorrected, expCorr);
        checkOutput({tag, "_marker_err"}, outMarkerErr, expMerr);
        nextCycle();
        checkOutput({tag, "_drained"}, outValid, 1'b0);
    endtask

    logic [7:0] cleanWords [4] = '{8'h80, 8'h8B, 8'hC5, 8'hFF};
    logic [3:0] cleanData  [4] = '{4'h0, 4'hB, 4'h5, 4'hF};
    logic [7:0] bpWords    [4] = '{8'h8B, 8'hC5, 8'hFF, 8'h80};
    logic [3:0] bpData     [4] = '{4'hB, 4'h5, 4'hF, 4'h0};

    initial begin
        int idx;
        int rx;
        logic accept;

        // Reset state
        #12;
        checkOutput("reset_out_valid", outValid, 1'b0);
        checkOutput("reset_out_data", outData, 4'h0);
        checkOutput("reset_flags", {outCorrected, outMarkerErr}, 2'b00);
        checkOutput("reset_in_ready", inReady, 1'b1);
        checkOutput("reset_stat_corr", statCorrected, 0);
        checkOutput("reset_stat_merr", statMarkerErr, 0);
        @(negedge clock);
        reset = 1'b1;
        nextCycle();

        // Clean words back to back, output two cycles after presentation
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(1'b1, cleanWords[i], 1'b1);
            else       applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("clean_in_ready", inReady, 1'b1);
            if (i >= 2) begin
                checkOutput("clean_valid", outValid, 1'b1);
                checkOutput("clean_data", outData, cleanData[i-2]);
                checkOutput("clean_flags", {outCorrected, outMarkerErr}, 2'b00);
            end
            nextCycle();
        end
        checkOutput("clean_drained", outValid, 1'b0);
        checkOutput("clean_stat_corr", statCorrected, 0);

        // Single errors and marker error
        sendSingle("data_err", 8'h8F, 4'hB, 1'b1, 1'b0, 3'b111);
        checkOutput("data_err_stat", statCorrected, statExp(1));
        sendSingle("parity_err", 8'hE5, 4'h5, 1'b1, 1'b0, 3'b010);
        checkOutput("parity_err_stat", statCorrected, statExp(2));
        sendSingle("marker_err", 8'h0B, 4'hB, 1'b0, 1'b1, 3'b000);
        checkOutput("marker_err_stat", statMarkerErr, statExp(1));
        checkOutput("marker_err_stat_corr", statCorrected, statExp(2));

        // Back-pressure: stall 6 cycles, then release and drain
        idx = 0;
        rx  = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(idx < 4, (idx < 4) ? bpWords[idx] : 8'h00, c >= 6);
            if (c == 5) begin
                checkOutput("bp_accepted", idx, 2);
                checkOutput("bp_in_ready_low", inReady, 1'b0);
            end
            if (c >= 2 && c < 6) checkOutput("bp_hold", {outValid, outData}, 5'h1B);
            if (outValid && outReady) begin
                if (rx < 4) checkOutput("bp_order", outData, bpData[rx]);
                else        checkOutput("bp_no_extra_word", outValid, 1'b0);
                rx++;
            end
            accept = inValid && inReady;
            nextCycle();
            if (accept) idx++;
        end
        checkOutput("bp_delivered", rx, 4);
        checkOutput("bp_all_accepted", idx, 4);

        // Counters: clear, saturate, clear colliding with a corrected transfer
        clearStats = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        nextCycle();
        clearStats = 1'b0;
        checkOutput("clear_stat_corr", statCorrected, 0);
        checkOutput("clear_stat_merr", statMarkerErr, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h8F, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) nextCycle();
        checkOutput("sat_drained", outValid, 1'b0);
        checkOutput("sat_stat_corr", statCorrected, statExp(3));
        checkOutput("sat_stat_merr", statMarkerErr, 0);
        applyStimulus(1'b1, 8'h8F, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1);
        nextCycle();
        checkOutput("clr_xfer_valid", outValid, 1'b1);
        clearStats = 1'b1;
        nextCycle();
        clearStats = 1'b0;
        checkOutput("clr_xfer_stat", statCorrected, 0);
        checkOutput("clr_xfer_done", outValid, 1'b0);
        nextCycle();
        checkOutput("clr_xfer_stat_hold", statCorrected, 0);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 8'h8B, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 8'hC5, 1'b1);
        nextCycle();
        checkOutput("rst_pre_valid", outValid, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", outValid, 1'b0);
        checkOutput("rst_out_data", outData, 4'h0);
        checkOutput("rst_flags", {outCorrected, outMarkerErr}, 2'b00);
        checkOutput("rst_in_ready", inReady, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("rst_no_stale", outValid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
